// File: rtl/mem_bus2_initiator.sv
// Cache-side bus2 master: takes one line request at a time, runs the C2/A2/D2
// read or write handshake with the responder and reports completion or timeout.
module mem_bus2_initiator #(
    parameter int ADDR2_BUS_SIZE = 14,
    parameter int DATA2_BUS_SIZE = 16,
    parameter int CTR2_BUS_SIZE  = 2,
    parameter int LINE_BYTES     = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        CLK,
    input  logic                        RESET,
    inout  wire  [ADDR2_BUS_SIZE-1:0]   A2_WIRE,
    inout  wire  [DATA2_BUS_SIZE-1:0]   D2_WIRE,
    inout  wire  [CTR2_BUS_SIZE-1:0]    C2_WIRE,
    input  logic                        req_valid,
    input  logic                        req_write,
    input  logic [ADDR2_BUS_SIZE-1:0]   req_addr,
    input  logic [LINE_BYTES*8-1:0]     req_wdata,
    output logic                        req_ready,
    output logic                        resp_valid,
    output logic                        resp_err,
    output logic [LINE_BYTES*8-1:0]     resp_rdata
);

    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / DATA2_BUS_SIZE;
    localparam int BW     = $clog2(BEATS);
    localparam int TW     = $clog2(TIMEOUT_CYCLES);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    // The counter is compared before its increment lands, hence the -2.
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 2);

    localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

    typedef enum logic [2:0] {
        TURN, IDLE, CMD_RD, WR_BEAT, WAIT_RESP, RD_BEAT
    } state_t;

    state_t                     state_q, state_d;
    logic                       a2_en_q, a2_en_d, d2_en_q, d2_en_d, c2_en_q, c2_en_d;
    logic [ADDR2_BUS_SIZE-1:0]  a2_q, a2_d;
    logic [DATA2_BUS_SIZE-1:0]  d2_q, d2_d;
    logic [CTR2_BUS_SIZE-1:0]   c2_q, c2_d;
    logic                       req_ready_q, req_ready_d;
    logic                       resp_valid_q, resp_valid_d;
    logic                       resp_err_q, resp_err_d;
    logic [LINE_W-1:0]          resp_rdata_q, resp_rdata_d;
    logic [LINE_W-1:0]          line_q, line_d;
    logic                       write_q, write_d;
    logic [BW-1:0]              beat_q, beat_d;
    logic [TW-1:0]              tmo_q, tmo_d;

    assign A2_WIRE = a2_en_q ? a2_q : 'z;
    assign D2_WIRE = d2_en_q ? d2_q : 'z;
    assign C2_WIRE = c2_en_q ? c2_q : 'z;

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    always_comb begin
        state_d      = state_q;
        a2_en_d      = a2_en_q;
        d2_en_d      = d2_en_q;
        c2_en_d      = c2_en_q;
        a2_d         = a2_q;
        d2_d         = d2_q;
        c2_d         = c2_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        line_d       = line_q;
        write_d      = write_q;
        beat_d       = beat_q;
        tmo_d        = tmo_q;

        case (state_q)
            TURN: begin
                state_d     = IDLE;
                c2_en_d     = 1'b1;
                c2_d        = C2_NOP;
                a2_en_d     = 1'b0;
                d2_en_d     = 1'b0;
                req_ready_d = 1'b1;
            end
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d     = req_write;
                    line_d      = req_wdata;
                    req_ready_d = 1'b0;
                    beat_d      = '0;
                    c2_en_d     = 1'b1;
                    a2_en_d     = 1'b1;
                    a2_d        = req_addr;
                    if (req_write) begin
                        state_d = WR_BEAT;
                        c2_d    = C2_WRITE_LINE;
                        d2_en_d = 1'b1;
                        d2_d    = req_wdata[DATA2_BUS_SIZE-1:0];
                    end else begin
                        state_d = CMD_RD;
                        c2_d    = C2_READ_LINE;
                    end
                end
            end
            CMD_RD: begin
                state_d = WAIT_RESP;
                a2_en_d = 1'b0;
                d2_en_d = 1'b0;
                c2_en_d = 1'b0;
                tmo_d   = '0;
            end
            WR_BEAT: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = WAIT_RESP;
                    a2_en_d = 1'b0;
                    d2_en_d = 1'b0;
                    c2_en_d = 1'b0;
                    tmo_d   = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                    d2_d   = line_q[(int'(beat_q) + 1) * DATA2_BUS_SIZE +: DATA2_BUS_SIZE];
                end
            end
            WAIT_RESP: begin
                tmo_d = tmo_q + 1'b1;
                // Response wins over a timeout landing on the same edge.
                if (C2_WIRE == C2_RESPONSE) begin
                    if (write_q) begin
                        state_d      = TURN;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d                       = RD_BEAT;
                        line_d[DATA2_BUS_SIZE-1:0]    = D2_WIRE;
                        beat_d                        = BW'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d      = TURN;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
            end
            RD_BEAT: begin
                line_d[int'(beat_q) * DATA2_BUS_SIZE +: DATA2_BUS_SIZE] = D2_WIRE;
                if (beat_q == LAST_BEAT) begin
                    state_d      = TURN;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = line_d;
                    beat_d       = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = TURN;
        endcase
    end

    always_ff @(posedge CLK) begin
        a2_q    <= a2_d;
        d2_q    <= d2_d;
        c2_q    <= c2_d;
        line_q  <= line_d;
        write_q <= write_d;
        if (RESET) begin
            state_q      <= TURN;
            a2_en_q      <= 1'b0;
            d2_en_q      <= 1'b0;
            c2_en_q      <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            beat_q       <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            a2_en_q      <= a2_en_d;
            d2_en_q      <= d2_en_d;
            c2_en_q      <= c2_en_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            beat_q       <= beat_d;
            tmo_q        <= tmo_d;
        end
    end

endmodule

// File: tb/tb_mem_bus2_initiator.sv
// Directed bench for mem_bus2_initiator: a bench-side responder plus a
// response scoreboard; released buses read back as all ones via pull-ups.
module tb_mem_bus2_initiator;

    localparam int LW = 128;
    localparam logic [1:0]  C_REL = 2'b11;
    localparam logic [13:0] A_REL = 14'h3FFF;
    localparam logic [15:0] D_REL = 16'hFFFF;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [13:0]   req_addr = '0;
    logic [LW-1:0] req_wdata = '0;
    logic          req_ready, resp_valid, resp_err;
    logic [LW-1:0] resp_rdata;

    wire  [13:0]   A2_WIRE;
    wire  [15:0]   D2_WIRE;
    wire  [1:0]    C2_WIRE;

    logic          rsp_c2_en = 1'b0;
    logic [1:0]    rsp_c2 = '0;
    logic          rsp_d2_en = 1'b0;
    logic [15:0]   rsp_d2 = '0;

    assign C2_WIRE = rsp_c2_en ? rsp_c2 : 'z;
    assign D2_WIRE = rsp_d2_en ? rsp_d2 : 'z;
    pullup pu_a2 (A2_WIRE);
    pullup pu_d2 (D2_WIRE);
    pullup pu_c2 (C2_WIRE);

    mem_bus2_initiator dut (
        .CLK(CLK), .RESET(RESET),
        .A2_WIRE(A2_WIRE), .D2_WIRE(D2_WIRE), .C2_WIRE(C2_WIRE),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic          err;
        logic [LW-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;
    int last_resp_cyc = -1;
    logic [LW-1:0] last_rdata = '0;

    task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_bus(input string nm, input logic [1:0] c, input logic [13:0] a, input logic [15:0] d);
        check(nm, LW'({C2_WIRE, A2_WIRE, D2_WIRE}), LW'({c, a, d}));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic respond_read(input logic [LW-1:0] line);
        for (int k = 0; k < 8; k++) begin
            rsp_c2_en = 1'b1;
            rsp_c2    = 2'd1;
            rsp_d2_en = 1'b1;
            rsp_d2    = line[16*k +: 16];
            tick();
        end
        rsp_c2_en = 1'b0;
        rsp_d2_en = 1'b0;
    endtask

    task automatic chk_idle(input string nm);
        chk_bus({nm, "_bus"}, 2'd0, A_REL, D_REL);
        check({nm, "_ready"}, LW'(req_ready), LW'(1'b1));
    endtask

    // Read with the responder answering after w silent wait cycles.
    task automatic do_read(input string nm, input logic [13:0] addr, input logic [LW-1:0] line, input int w);
        int t_acc;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        sb.push_back('{1'b0, line});
        last_rdata = line;
        tick();
        t_acc = cyc;
        req_valid = 1'b0;
        chk_bus({nm, "_cmd"}, 2'd2, addr, D_REL);
        check({nm, "_ready_low"}, LW'(req_ready), LW'(1'b0));
        tick();
        chk_bus({nm, "_wait"}, C_REL, A_REL, D_REL);
        repeat (w) tick();
        respond_read(line);
        settle();
        check({nm, "_latency"}, LW'(last_resp_cyc - t_acc), LW'(1 + w + 8));
        chk_bus({nm, "_turn"}, C_REL, A_REL, D_REL);
        tick();
        check({nm, "_pulse"}, LW'(resp_valid), LW'(1'b0));
        chk_idle({nm, "_idle"});
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (resp_valid === 1'b1) begin
            last_resp_cyc <= cyc;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL resp_unexpected: resp_valid=1 with nothing outstanding, required 0");
            end else begin
                e = sb.pop_front();
                check("resp_err", LW'(resp_err), LW'(e.err));
                check("resp_rdata", resp_rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LW-1:0] wl;
        int t_acc;
        int n;
        wl = 128'h0F0E0D0C0B0A09080706050403020100;

        // Reset and the dead cycle that follows it
        tick();
        tick();
        chk_bus("reset_bus", C_REL, A_REL, D_REL);
        check("reset_ctl", LW'({req_ready, resp_valid, resp_err}), '0);
        check("reset_rdata", resp_rdata, '0);
        tick();
        RESET = 1'b0;
        chk_bus("turn_bus", C_REL, A_REL, D_REL);
        check("turn_ready", LW'(req_ready), LW'(1'b0));
        tick();
        chk_idle("first_idle");

        // Read line, response 10 cycles after the command
        do_read("rd1", 14'h1A5, 128'hFFEEDDCCBBAA99887766554433221100, 9);

        // Write line, response 5 cycles after release; rdata must stay put
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 14'h0042;
        req_wdata = wl;
        sb.push_back('{1'b0, last_rdata});
        tick();
        t_acc = cyc;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wdata = '0;
        for (int k = 0; k < 8; k++) begin
            chk_bus($sformatf("wr_beat%0d", k), 2'd3, 14'h0042, wl[16*k +: 16]);
            tick();
        end
        chk_bus("wr_release", C_REL, A_REL, D_REL);
        repeat (4) tick();
        rsp_c2_en = 1'b1;
        rsp_c2    = 2'd1;
        tick();
        rsp_c2_en = 1'b0;
        settle();
        check("wr_latency", LW'(last_resp_cyc - t_acc), LW'(13));
        tick();
        chk_idle("wr_idle");

        // Timeout with a silent responder
        req_valid = 1'b1;
        req_addr  = 14'h0003;
        sb.push_back('{1'b1, last_rdata});
        tick();
        t_acc = cyc;
        req_valid = 1'b0;
        chk_bus("to_cmd", 2'd2, 14'h0003, D_REL);
        n = 0;
        while (resp_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("to_seen", LW'(resp_valid), LW'(1'b1));
        settle();
        check("to_latency", LW'(last_resp_cyc - t_acc), LW'(256));
        tick();
        chk_idle("to_idle");

        // Reset while beat 4 of a write is on the bus
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 14'h0042;
        req_wdata = wl;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        repeat (4) tick();
        chk_bus("abort_beat4", 2'd3, 14'h0042, wl[79:64]);
        RESET = 1'b1;
        tick();
        chk_bus("abort_release", C_REL, A_REL, D_REL);
        check("abort_ctl", LW'({req_ready, resp_valid}), '0);
        RESET = 1'b0;
        tick();
        chk_idle("abort_idle");
        do_read("rd2", 14'h0077, 128'h0123456789ABCDEF_FEDCBA9876543210, 2);

        // Back-to-back reads with req_valid held high
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 14'h0010;
        sb.push_back('{1'b0, 128'hA0A1A2A3A4A5A6A7_B0B1B2B3B4B5B6B7});
        sb.push_back('{1'b0, 128'h5555AAAA5555AAAA_C3C3_3C3C_0F0F_F0F0});
        tick();
        t_acc = cyc;
        req_addr = 14'h0020;
        chk_bus("b2b_cmd1", 2'd2, 14'h0010, D_REL);
        tick();
        respond_read(128'hA0A1A2A3A4A5A6A7_B0B1B2B3B4B5B6B7);
        settle();
        check("b2b_latency1", LW'(last_resp_cyc - t_acc), LW'(9));
        chk_bus("b2b_dead", C_REL, A_REL, D_REL);
        tick();
        chk_bus("b2b_nop", 2'd0, A_REL, D_REL);
        tick();
        chk_bus("b2b_cmd2", 2'd2, 14'h0020, D_REL);
        check("b2b_gap", LW'(cyc - last_resp_cyc), LW'(2));
        req_valid = 1'b0;
        tick();
        respond_read(128'h5555AAAA5555AAAA_C3C3_3C3C_0F0F_F0F0);
        settle();
        tick();
        chk_idle("b2b_idle");

        check("sb_empty", LW'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
